line_follower: RTL and testbench

Top level of the line-following cart. Receives go/stop commands over a UART line, polls six IR line sensors through an SPI A/D converter, and steers two PWM-driven motors along the line. It stops when the barcode reader reports the destination station ID, and sounds a buzzer whenever it is in transit but blocked by the obstacle sensor (OK2Move low).

---
 rtl/line_follower_if.sv | 10 +
 rtl/line_follower.sv | 384 ++++++++++++++++++++++++++++++++++++++
 tb/tb_line_follower.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_follower_if.sv
// SPI link between the cart controller and the six-channel IR A/D converter.
interface line_follower_if;
    logic a2d_SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output a2d_SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input a2d_SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/line_follower.sv
// Line-following cart top level: UART go/stop commands, barcode station
// reader, SPI A/D sweep of six IR sensors, proportional PWM steering and an
// obstacle buzzer. OK2Move is expected to arrive already synchronous to clk
// (debounced upstream) so the motors and buzzer can react within one clock.
module line_follower #(
    parameter int          BAUD_DIV  = 2604,
    parameter int          BUZZ_HALF = 6250,
    parameter logic [10:0] PWM_BASE  = 11'h300,
    parameter int          SCLK_DIV  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RX,
    input  logic             BC,
    input  logic             OK2Move,
    line_follower_if.master  a2d,
    output logic             IR_in_en,
    output logic             IR_mid_en,
    output logic             IR_out_en,
    output logic             fwd_lft,
    output logic             rev_lft,
    output logic             fwd_rht,
    output logic             rev_rht,
    output logic             in_transit,
    output logic             buzz,
    output logic             buzz_n,
    output logic [7:0]       led
);

    localparam logic [15:0] BAUD_LAST  = 16'(BAUD_DIV - 1);
    localparam logic [15:0] BAUD_MID   = 16'(BAUD_DIV / 2 - 1);
    localparam logic [15:0] BUZZ_LAST  = 16'(BUZZ_HALF - 1);
    localparam logic [9:0]  SCLK_HALF  = 10'(SCLK_DIV / 2 - 1);
    localparam logic [9:0]  SCLK_LAST  = 10'(SCLK_DIV - 1);
    localparam logic [9:0]  GAP_LAST   = 10'(2 * SCLK_DIV - 1);

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
    typedef enum logic [1:0] {B_IDLE, B_START, B_WAIT, B_DELAY} bc_state_t;
    typedef enum logic [1:0] {S_IDLE, S_GAP, S_XFER} spi_state_t;

    logic [1:0]  rx_sync, bc_sync;
    logic        rx_s, bc_s, rx_prev, bc_prev, bc_fall;

    uart_state_t u_state, u_next;
    logic [15:0] u_cnt;
    logic [2:0]  u_bits;
    logic [7:0]  u_shift;
    logic        u_tick, cmd_valid;

    bc_state_t   b_state, b_next;
    logic [15:0] b_t, b_cnt;
    logic [2:0]  b_bits;
    logic [7:0]  b_shift, bc_id;
    logic        b_sample, bc_done;

    logic [5:0]  dest;

    spi_state_t  s_state, s_next;
    logic [9:0]  s_cnt;
    logic [3:0]  s_bit;
    logic [15:0] s_tx;
    logic [11:0] s_rx;
    logic [2:0]  chan, prev_chan;
    logic        primed, sweep_done, s_frame_end;
    logic        ss_n_r, sclk_r;
    logic [11:0] rd [0:5];

    logic signed [15:0] err, err_next, err_sh;
    logic signed [16:0] lft_sum, rht_sum;
    logic signed [11:0] lft_duty, rht_duty;
    logic [10:0] lft_mag, rht_mag, pwm_cnt;
    logic        lft_fwd_r, lft_rev_r, rht_fwd_r, rht_rev_r, run;

    logic [15:0] buzz_cnt;
    logic        buzz_r, buzz_act;

    function automatic logic signed [15:0] diff(input logic [11:0] r, input logic [11:0] l);
        return $signed({4'b0, r}) - $signed({4'b0, l});
    endfunction

    function automatic logic signed [11:0] sat12(input logic signed [16:0] v);
        if (v > 17'sd2047)
            return 12'sd2047;
        else if (v < -17'sd2047)
            return -12'sd2047;
        else
            return $signed(v[11:0]);
    endfunction

    assign rx_s    = rx_sync[1];
    assign bc_s    = bc_sync[1];
    assign bc_fall = bc_prev && !bc_s;

    // Two-flop synchronisers on the serial inputs plus a delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync <= 2'b11;
            bc_sync <= 2'b11;
            rx_prev <= 1'b1;
            bc_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], RX};
            bc_sync <= {bc_sync[0], BC};
            rx_prev <= rx_s;
            bc_prev <= bc_s;
        end
    end

    assign u_tick    = (u_cnt == 16'd0);
    assign cmd_valid = (u_state == U_STOP) && u_tick && rx_s;

    // UART receiver state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) u_state <= U_IDLE;
        else     u_state <= u_next;
    end

    // UART next state: start edge, mid-bit start check, eight data bits, stop bit.
    always_comb begin
        u_next = u_state;
        case (u_state)
            U_IDLE:  if (rx_prev && !rx_s) u_next = U_START;
            U_START: if (u_tick) u_next = rx_s ? U_IDLE : U_DATA;
            U_DATA:  if (u_tick && u_bits == 3'd7) u_next = U_STOP;
            U_STOP:  if (u_tick) u_next = U_IDLE;
            default: u_next = U_IDLE;
        endcase
    end

    // UART bit timer and LSB-first shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            u_cnt   <= BAUD_MID;
            u_bits  <= 3'd0;
            u_shift <= 8'd0;
        end else begin
            case (u_state)
                U_IDLE: begin
                    u_cnt  <= BAUD_MID;
                    u_bits <= 3'd0;
                end
                U_DATA: begin
                    if (u_tick) begin
                        u_cnt   <= BAUD_LAST;
                        u_shift <= {rx_s, u_shift[7:1]};
                        u_bits  <= u_bits + 3'd1;
                    end else begin
                        u_cnt <= u_cnt - 16'd1;
                    end
                end
                default: u_cnt <= u_tick ? BAUD_LAST : u_cnt - 16'd1;
            endcase
        end
    end

    assign b_sample = (b_state == B_DELAY) && (b_cnt >= b_t);
    assign bc_done  = b_sample && (b_bits == 3'd7);
    assign bc_id    = {b_shift[6:0], bc_s};

    // Barcode reader state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) b_state <= B_IDLE;
        else     b_state <= b_next;
    end

    // Barcode next state: measure start-bit low time, then sample each bit that long after its falling edge.
    always_comb begin
        b_next = b_state;
        case (b_state)
            B_IDLE:  if (bc_fall) b_next = B_START;
            B_START: if (bc_s) b_next = B_WAIT;
            B_WAIT:  if (bc_fall) b_next = B_DELAY;
            B_DELAY: if (b_sample) b_next = (b_bits == 3'd7) ? B_IDLE : B_WAIT;
            default: b_next = B_IDLE;
        endcase
    end

    // Barcode reference-period counter, per-bit delay counter and MSB-first shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_t     <= 16'd1;
            b_cnt   <= 16'd1;
            b_bits  <= 3'd0;
            b_shift <= 8'd0;
        end else begin
            case (b_state)
                B_IDLE: begin
                    b_t    <= 16'd1;
                    b_bits <= 3'd0;
                end
                B_START: if (!bc_s && b_t != 16'hFFFF) b_t <= b_t + 16'd1;
                B_WAIT:  b_cnt <= 16'd1;
                B_DELAY: begin
                    if (b_sample) begin
                        b_shift <= bc_id;
                        b_bits  <= b_bits + 3'd1;
                    end else begin
                        b_cnt <= b_cnt + 16'd1;
                    end
                end
                default: b_cnt <= 16'd1;
            endcase
        end
    end

    // Transit control: a command always beats a same-cycle barcode arrival.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_transit <= 1'b0;
            dest       <= 6'd0;
            led        <= 8'd0;
        end else begin
            if (bc_done && bc_id[7:6] == 2'b00)
                led <= bc_id;
            if (cmd_valid && u_shift[7:6] == 2'b01) begin
                in_transit <= 1'b1;
                dest       <= u_shift[5:0];
            end else if (cmd_valid && u_shift[7:6] == 2'b00) begin
                in_transit <= 1'b0;
            end else if (bc_done && bc_id[7:6] == 2'b00 && bc_id[5:0] == dest) begin
                in_transit <= 1'b0;
            end
        end
    end

    assign s_frame_end = (s_state == S_XFER) && (s_cnt == SCLK_LAST) && (s_bit == 4'd15);

    // SPI sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) s_state <= S_IDLE;
        else     s_state <= s_next;
    end

    // SPI next state: idle out of transit, otherwise alternate inter-frame gap and 16-bit frame.
    always_comb begin
        s_next = s_state;
        if (!in_transit) begin
            s_next = S_IDLE;
        end else begin
            case (s_state)
                S_IDLE:  s_next = S_GAP;
                S_GAP:   if (s_cnt == GAP_LAST) s_next = S_XFER;
                S_XFER:  if (s_frame_end) s_next = S_GAP;
                default: s_next = S_IDLE;
            endcase
        end
    end

    // SPI datapath: SCLK generation, MOSI/MISO shifting and round-robin channel bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_n_r     <= 1'b1;
            sclk_r     <= 1'b1;
            s_tx       <= 16'd0;
            s_rx       <= 12'd0;
            s_cnt      <= 10'd0;
            s_bit      <= 4'd0;
            chan       <= 3'd0;
            prev_chan  <= 3'd0;
            primed     <= 1'b0;
            sweep_done <= 1'b0;
            for (int i = 0; i < 6; i++) rd[i] <= 12'd0;
        end else begin
            sweep_done <= 1'b0;
            if (!in_transit) begin
                ss_n_r <= 1'b1;
                sclk_r <= 1'b1;
                s_tx   <= 16'd0;
                s_cnt  <= 10'd0;
                s_bit  <= 4'd0;
                chan   <= 3'd0;
                primed <= 1'b0;
            end else begin
                case (s_state)
                    S_GAP: begin
                        if (s_cnt == GAP_LAST) begin
                            ss_n_r <= 1'b0;
                            sclk_r <= 1'b0;
                            s_tx   <= {2'b00, chan, 11'd0};
                            s_cnt  <= 10'd0;
                            s_bit  <= 4'd0;
                        end else begin
                            s_cnt <= s_cnt + 10'd1;
                        end
                    end
                    S_XFER: begin
                        if (s_cnt == SCLK_HALF) begin
                            sclk_r <= 1'b1;
                            s_rx   <= {s_rx[10:0], a2d.MISO};
                        end
                        if (s_cnt == SCLK_LAST) begin
                            s_cnt <= 10'd0;
                            if (s_bit == 4'd15) begin
                                ss_n_r    <= 1'b1;
                                s_tx      <= 16'd0;
                                primed    <= 1'b1;
                                prev_chan <= chan;
                                chan      <= (chan == 3'd5) ? 3'd0 : chan + 3'd1;
                                if (primed) begin
                                    rd[prev_chan] <= s_rx;
                                    sweep_done    <= (prev_chan == 3'd5);
                                end
                            end else begin
                                sclk_r <= 1'b0;
                                s_tx   <= {s_tx[14:0], 1'b0};
                                s_bit  <= s_bit + 4'd1;
                            end
                        end else begin
                            s_cnt <= s_cnt + 10'd1;
                        end
                    end
                    default: s_cnt <= 10'd0;
                endcase
            end
        end
    end

    assign a2d.a2d_SS_n = ss_n_r;
    assign a2d.SCLK     = sclk_r;
    assign a2d.MOSI     = s_tx[15];

    assign err_next = diff(rd[1], rd[0]) + (diff(rd[3], rd[2]) <<< 1) + (diff(rd[5], rd[4]) <<< 2);
    assign err_sh   = err >>> 3;
    assign lft_sum  = $signed({6'b0, PWM_BASE}) + $signed({err_sh[15], err_sh});
    assign rht_sum  = $signed({6'b0, PWM_BASE}) - $signed({err_sh[15], err_sh});
    assign lft_duty = sat12(lft_sum);
    assign rht_duty = sat12(rht_sum);
    assign lft_mag  = lft_duty[11] ? 11'(-lft_duty) : lft_duty[10:0];
    assign rht_mag  = rht_duty[11] ? 11'(-rht_duty) : rht_duty[10:0];

    // Steering error is refreshed only once a complete six-channel sweep has landed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             err <= 16'sd0;
        else if (sweep_done) err <= err_next;
    end

    // Free-running PWM counter and registered forward/reverse compare per motor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt   <= 11'd0;
            lft_fwd_r <= 1'b0;
            lft_rev_r <= 1'b0;
            rht_fwd_r <= 1'b0;
            rht_rev_r <= 1'b0;
        end else begin
            pwm_cnt   <= pwm_cnt + 11'd1;
            lft_fwd_r <= !lft_duty[11] && (pwm_cnt < lft_mag);
            lft_rev_r <=  lft_duty[11] && (pwm_cnt < lft_mag);
            rht_fwd_r <= !rht_duty[11] && (pwm_cnt < rht_mag);
            rht_rev_r <=  rht_duty[11] && (pwm_cnt < rht_mag);
        end
    end

    assign run     = in_transit && OK2Move;
    assign fwd_lft = run && lft_fwd_r;
    assign rev_lft = run && lft_rev_r;
    assign fwd_rht = run && rht_fwd_r;
    assign rev_rht = run && rht_rev_r;

    assign IR_in_en  = in_transit;
    assign IR_mid_en = in_transit;
    assign IR_out_en = in_transit;

    assign buzz_act = in_transit && !OK2Move;
    assign buzz     = buzz_act && buzz_r;
    assign buzz_n   = buzz_act && !buzz_r;

    // Buzzer half-period divider, held cleared whenever the cart is not blocked in transit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buzz_cnt <= 16'd0;
            buzz_r   <= 1'b0;
        end else if (!buzz_act) begin
            buzz_cnt <= 16'd0;
            buzz_r   <= 1'b0;
        end else if (buzz_cnt == BUZZ_LAST) begin
            buzz_cnt <= 16'd0;
            buzz_r   <= !buzz_r;
        end else begin
            buzz_cnt <= buzz_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_line_follower.sv
// Self-checking bench for line_follower: UART commands, barcode frames and an
// A/D slave model driven from randomized sensor readings, with expectations
// taken from a behavioural model of the cart's rules.
module tb_line_follower;

    localparam int BAUD = 32;
    localparam int BUZZ = 250;
    localparam int SDIV = 8;
    localparam int BASE = 768;

    logic clk = 1'b0;
    logic rst, RX, BC, OK2Move;
    logic IR_in_en, IR_mid_en, IR_out_en;
    logic fwd_lft, rev_lft, fwd_rht, rev_rht;
    logic in_transit, buzz, buzz_n;
    logic [7:0] led;

    line_follower_if a2d();

    line_follower #(.BAUD_DIV(BAUD), .BUZZ_HALF(BUZZ), .PWM_BASE(11'h300), .SCLK_DIV(SDIV)) dut (
        .clk(clk), .rst(rst), .RX(RX), .BC(BC), .OK2Move(OK2Move), .a2d(a2d),
        .IR_in_en(IR_in_en), .IR_mid_en(IR_mid_en), .IR_out_en(IR_out_en),
        .fwd_lft(fwd_lft), .rev_lft(rev_lft), .fwd_rht(fwd_rht), .rev_rht(rev_rht),
        .in_transit(in_transit), .buzz(buzz), .buzz_n(buzz_n), .led(led)
    );

    always #5 clk = ~clk;

    int num_checks = 0;
    int num_errors = 0;

    logic       m_transit;
    logic [5:0] m_dest;
    logic [7:0] m_led;

    logic [11:0] sensor [0:5];
    logic [15:0] ad_word, ad_mosi;
    int          ad_rise, ad_prev_addr, ss_falls;
    logic        prev_ss, prev_sclk, miso_bit;

    assign a2d.MISO = miso_bit;

    // A/D slave: returns the reading of the channel addressed in the previous frame.
    initial begin
        miso_bit = 1'b0; prev_ss = 1'b1; prev_sclk = 1'b1;
        ad_rise = 0; ad_prev_addr = 0; ss_falls = 0; ad_mosi = '0; ad_word = '0;
        forever begin
            @(negedge clk);
            if (prev_ss && !a2d.a2d_SS_n) begin
                ss_falls++;
                ad_rise  = 0;
                ad_word  = {4'b0, sensor[ad_prev_addr]};
                miso_bit = ad_word[15];
            end else if (!a2d.a2d_SS_n && !prev_sclk && a2d.SCLK) begin
                ad_mosi = {ad_mosi[14:0], a2d.MOSI};
                ad_rise++;
                if (ad_rise < 16) miso_bit = ad_word[15 - ad_rise];
            end
            if (!prev_ss && a2d.a2d_SS_n && ad_rise == 16 && ad_mosi[13:11] < 3'd6)
                ad_prev_addr = int'(ad_mosi[13:11]);
            prev_ss   = a2d.a2d_SS_n;
            prev_sclk = a2d.SCLK;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends one UART byte; a bad stop bit must leave the model untouched.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_ok);
        RX = 1'b0; tick(BAUD);
        for (int i = 0; i < 8; i++) begin
            RX = b[i]; tick(BAUD);
        end
        RX = stop_ok; tick(BAUD);
        RX = 1'b1; tick(BAUD);
        if (stop_ok) begin
            if (b[7:6] == 2'b01) begin
                m_transit = 1'b1;
                m_dest    = b[5:0];
            end else if (b[7:6] == 2'b00) begin
                m_transit = 1'b0;
            end
        end
    endtask

    // Barcode frame: start low P/2, then '1' low P/4 and '0' low 3P/4 per bit.
    task automatic sendBarcode(input logic [7:0] id, input int p);
        BC = 1'b0; tick(p / 2);
        BC = 1'b1; tick(p / 2);
        for (int i = 7; i >= 0; i--) begin
            BC = 1'b0; tick(id[i] ? p / 4 : 3 * p / 4);
            BC = 1'b1; tick(id[i] ? 3 * p / 4 : p / 4);
        end
        tick(10);
        if (id[7:6] == 2'b00) begin
            m_led = id;
            if (m_transit && id[5:0] == m_dest) m_transit = 1'b0;
        end
    endtask

    function automatic int clampDuty(input int v);
        if (v > 2047)  return 2047;
        if (v < -2047) return -2047;
        return v;
    endfunction

    function automatic int floorDiv8(input int v);
        return (v >= 0) ? v / 8 : -((-v + 7) / 8);
    endfunction

    // Lets several sweeps settle, then counts drive cycles over one full PWM period.
    task automatic measureDuty(input string tag);
        int e, l, r, lf, lr, rf, rr, both;
        e = (int'(sensor[1]) - int'(sensor[0])) + 2 * (int'(sensor[3]) - int'(sensor[2]))
            + 4 * (int'(sensor[5]) - int'(sensor[4]));
        l = clampDuty(BASE + floorDiv8(e));
        r = clampDuty(BASE - floorDiv8(e));
        tick(3000);
        lf = 0; lr = 0; rf = 0; rr = 0; both = 0;
        for (int c = 0; c < 2048; c++) begin
            tick(1);
            lf += int'(fwd_lft); lr += int'(rev_lft);
            rf += int'(fwd_rht); rr += int'(rev_rht);
            if ((fwd_lft && rev_lft) || (fwd_rht && rev_rht)) both++;
        end
        checkOutput({tag, "_lft_fwd"}, lf, (l > 0) ? l : 0);
        checkOutput({tag, "_lft_rev"}, lr, (l < 0) ? -l : 0);
        checkOutput({tag, "_rht_fwd"}, rf, (r > 0) ? r : 0);
        checkOutput({tag, "_rht_rev"}, rr, (r < 0) ? -r : 0);
        checkOutput({tag, "_overlap"}, both, 0);
    endtask

    initial begin
        int falls0, tog_b, tog_bn, first_rise, hi_len, hi_first, comp_bad;
        logic pb, pbn, in_pulse;
        logic [7:0] rb;

        rst = 1'b1; RX = 1'b1; BC = 1'b1; OK2Move = 1'b1;
        m_transit = 1'b0; m_dest = 6'd0; m_led = 8'd0;
        for (int i = 0; i < 6; i++) sensor[i] = 12'd1000;
        tick(5);
        checkOutput("rst_transit", in_transit, 0);
        checkOutput("rst_led", led, 0);
        checkOutput("rst_spi", {a2d.a2d_SS_n, a2d.SCLK, a2d.MOSI}, 3'b110);
        checkOutput("rst_motors", {fwd_lft, rev_lft, fwd_rht, rev_rht}, 0);
        checkOutput("rst_ir", {IR_in_en, IR_mid_en, IR_out_en}, 0);
        checkOutput("rst_buzz", {buzz, buzz_n}, 0);
        rst = 1'b0;
        tick(10);

        applyStimulus(8'h41, 1'b0);
        checkOutput("framing_err", in_transit, m_transit);
        applyStimulus(8'h41, 1'b1);
        checkOutput("go_transit", in_transit, m_transit);
        checkOutput("go_ir", {IR_in_en, IR_mid_en, IR_out_en}, {3{m_transit}});
        falls0 = ss_falls;
        tick(1000);
        checkOutput("spi_active", (ss_falls - falls0) > 2, 1);

        measureDuty("equal");
        sensor[1] = 12'd4000;
        measureDuty("inner_r");
        sensor[0] = 12'd0; sensor[1] = 12'd0; sensor[2] = 12'd0;
        sensor[3] = 12'd4095; sensor[4] = 12'd0; sensor[5] = 12'd4095;
        measureDuty("saturate");
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 6; i++) sensor[i] = 12'($urandom_range(0, 4095));
            measureDuty($sformatf("rand%0d", k));
        end

        OK2Move = 1'b0;
        tick(1);
        checkOutput("blocked_motors", {fwd_lft, rev_lft, fwd_rht, rev_rht}, 0);
        pb = 1'b0; pbn = 1'b0; in_pulse = 1'b0;
        tog_b = 0; tog_bn = 0; first_rise = -1; hi_len = 0; hi_first = -1; comp_bad = 0;
        for (int c = 2; c <= 2000; c++) begin
            tick(1);
            if (buzz != pb) tog_b++;
            if (buzz_n != pbn) tog_bn++;
            if (buzz_n !== !buzz) comp_bad++;
            if (buzz && !pb) begin
                if (first_rise < 0) first_rise = c;
                in_pulse = 1'b1; hi_len = 0;
            end
            if (buzz && in_pulse) hi_len++;
            if (!buzz && pb && in_pulse && hi_first < 0) hi_first = hi_len;
            pb = buzz; pbn = buzz_n;
        end
        checkOutput("buzz_toggles", tog_b >= 2, 1);
        checkOutput("buzz_n_toggles", tog_bn >= 2, 1);
        checkOutput("buzz_first_rise", (first_rise >= BUZZ - 1) && (first_rise <= BUZZ + 1), 1);
        checkOutput("buzz_high_time", hi_first, BUZZ);
        checkOutput("buzz_complement", comp_bad, 0);
        OK2Move = 1'b1;
        tick(5);

        sendBarcode(8'h02, 256);
        checkOutput("bc02_led", led, m_led);
        checkOutput("bc02_transit", in_transit, m_transit);
        sendBarcode(8'hC1, 256);
        checkOutput("bcC1_led", led, m_led);
        checkOutput("bcC1_transit", in_transit, m_transit);
        sendBarcode(8'h01, 1024);
        checkOutput("bc01_led", led, m_led);
        checkOutput("bc01_transit", in_transit, m_transit);
        checkOutput("bc01_buzz", {buzz, buzz_n}, 0);

        applyStimulus(8'h45, 1'b1);
        checkOutput("go05_transit", in_transit, m_transit);
        applyStimulus(8'h00, 1'b1);
        checkOutput("stop_transit", in_transit, m_transit);
        checkOutput("stop_motors", {fwd_lft, rev_lft, fwd_rht, rev_rht}, 0);
        applyStimulus(8'h80, 1'b1);
        checkOutput("ignored_80", in_transit, m_transit);

        for (int k = 0; k < 5; k++) begin
            rb = 8'($urandom_range(0, 255));
            applyStimulus(rb, 1'b1);
            checkOutput($sformatf("rcmd%0d_transit", k), in_transit, m_transit);
        end
        applyStimulus({2'b01, 6'($urandom_range(0, 63))}, 1'b1);
        for (int k = 0; k < 4; k++) begin
            case ($urandom_range(0, 2))
                0:       rb = {2'b00, m_dest};
                1:       rb = {2'b00, 6'($urandom_range(0, 63))};
                default: rb = {2'($urandom_range(1, 3)), 6'($urandom_range(0, 63))};
            endcase
            if (k == 3) rb = {2'b00, m_dest};
            sendBarcode(rb, 256);
            checkOutput($sformatf("rbc%0d_led", k), led, m_led);
            checkOutput($sformatf("rbc%0d_transit", k), in_transit, m_transit);
        end

        RX = 1'b0; tick(BAUD);
        RX = 1'b1; tick(BAUD);
        RX = 1'b0; tick(BAUD);
        rst = 1'b1;
        tick(2);
        m_transit = 1'b0; m_dest = 6'd0; m_led = 8'd0;
        checkOutput("midrst_transit", in_transit, m_transit);
        checkOutput("midrst_led", led, m_led);
        RX = 1'b1;
        rst = 1'b0;
        tick(BAUD * 10);
        checkOutput("midrst_after", in_transit, m_transit);
        checkOutput("midrst_ss", a2d.a2d_SS_n, 1);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
